// File: rtl/clk_set_pkg.sv
// clk_set_pkg: shared types and constants for the clock-setting path.
// Contents: debounce FSM state type, idle-counter width, default timeout,
// and the 2-bit mode encodings used by the downstream mode counter.
package clk_set_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_t;

    localparam int TG_W            = 5;
    localparam int TIMEOUT_DEFAULT = 20;

    localparam logic [1:0] MODE_RUN = 2'd0;
    localparam logic [1:0] MODE_SEC = 2'd1;
    localparam logic [1:0] MODE_MIN = 2'd2;

    // The debounced level is high once a press is accepted and stays high
    // until the release has been confirmed.
    function automatic logic is_level_high(input db_state_t st);
        return (st == PRESSED) || (st == WAIT_RELEASE);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: free-running prescaler producing a one-cycle tick per second.
// Ports:
//   ckht     in  system clock
//   rst      in  synchronous reset, active-high
//   sec_tick out registered pulse on the cycle after the counter wraps
// Only rst clears the count, so the tick phase is never realigned.
module sec_tick_gen #(
    parameter int SEC_CYCLES = 50_000_000
) (
    input  logic ckht,
    input  logic rst,
    output logic sec_tick
);

    localparam int PC_W = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            tick_q, tick_d;

    always_comb begin
        tick_d = (pc_q == PC_W'(SEC_CYCLES - 1));
        pc_d   = tick_d ? '0 : pc_q + 1'b1;
    end

    always_ff @(posedge ckht) begin
        if (rst) begin
            pc_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tick_q <= tick_d;
        end
    end

    assign sec_tick = tick_q;

endmodule

// File: rtl/btn_mod_ctrl.sv
// btn_mod_ctrl: mode-button synchroniser/debouncer plus idle-seconds counter.
// Ports:
//   ckht        in  system clock
//   rst         in  synchronous reset, active-high
//   btn_mod     in  raw mode button, active-high, asynchronous
//   act_in      in  activity pulse from the adjust buttons
//   mode_active in  high while the downstream mode is not MODE_RUN
//   ena_db      out one-cycle pulse per accepted press
//   btn_level   out debounced button level
//   sec_tick    out one-cycle pulse every SEC_CYCLES cycles
//   tg_nn       out idle seconds, saturating at TIMEOUT_S
// Optional feature: define BTN_AUTOREPEAT_EN to emit an extra ena_db pulse
// every REPEAT_CYCLES cycles while the button stays pressed.
module btn_mod_ctrl
    import clk_set_pkg::*;
#(
    parameter int DB_CYCLES     = 500_000,
    parameter int SEC_CYCLES    = 50_000_000,
    parameter int TIMEOUT_S     = TIMEOUT_DEFAULT,
    parameter int REPEAT_CYCLES = 25_000_000
) (
    input  logic            ckht,
    input  logic            rst,
    input  logic            btn_mod,
    input  logic            act_in,
    input  logic            mode_active,
    output logic            ena_db,
    output logic            btn_level,
    output logic            sec_tick,
    output logic [TG_W-1:0] tg_nn
);

    localparam int DC_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    if ((TIMEOUT_S > 31) || (TIMEOUT_S < 0)) begin : g_chk_timeout
        $error("btn_mod_ctrl: TIMEOUT_S must be within 0..31");
    end
    if (DB_CYCLES < 2) begin : g_chk_db
        $error("btn_mod_ctrl: DB_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 1) begin : g_chk_repeat
        $error("btn_mod_ctrl: REPEAT_CYCLES must be at least 1");
    end

    logic [1:0]      sync_q;
    logic            s;
    db_state_t       state_q, state_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic            dc_done;
    logic            press;
    logic            ena_q, ena_d;
    logic [TG_W-1:0] tg_q, tg_d;

    assign s = sync_q[1];

    // dc counts the stable samples after the first one, which is consumed
    // by the entry edge; the next increment completing DB_CYCLES samples
    // is the accepting one.
    assign dc_done = ({1'b0, dc_q} + 1'b1) == (DC_W + 1)'(DB_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        dc_d    = dc_q;
        press   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) state_d = WAIT_PRESS;
            end
            WAIT_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (dc_done) begin
                    state_d = PRESSED;
                    press   = 1'b1;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (dc_done) begin
                    state_d = IDLE;
                end else begin
                    dc_d = dc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) dc_d = '0;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RC_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    logic [RC_W-1:0] rc_q, rc_d;
    logic            stay;
    logic            rep;

    // The counter only runs while the FSM remains in PRESSED; entering
    // PRESSED (fresh press or bounce back from WAIT_RELEASE) starts it at 0.
    always_comb begin
        stay  = (state_q == PRESSED) && s;
        rep   = stay && (rc_q == RC_W'(REPEAT_CYCLES - 1));
        rc_d  = (!stay || rep) ? '0 : rc_q + 1'b1;
        ena_d = press | rep;
    end

    always_ff @(posedge ckht) begin
        if (rst) rc_q <= '0;
        else     rc_q <= rc_d;
    end
`else
    assign ena_d = press;
`endif

    // Any clear source wins over the second-tick increment.
    always_comb begin
        tg_d = (ena_q | act_in | ~mode_active) ? '0 :
               (sec_tick && (tg_q < TG_W'(TIMEOUT_S))) ? tg_q + 1'b1 : tg_q;
    end

    always_ff @(posedge ckht) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= IDLE;
            dc_q    <= '0;
            ena_q   <= 1'b0;
            tg_q    <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_mod};
            state_q <= state_d;
            dc_q    <= dc_d;
            ena_q   <= ena_d;
            tg_q    <= tg_d;
        end
    end

    sec_tick_gen #(
        .SEC_CYCLES(SEC_CYCLES)
    ) u_sec_tick_gen (
        .ckht    (ckht),
        .rst     (rst),
        .sec_tick(sec_tick)
    );

    assign ena_db    = ena_q;
    assign btn_level = is_level_high(state_q);
    assign tg_nn     = tg_q;

endmodule

// File: tb/tb_btn_mod_ctrl.sv
// tb_btn_mod_ctrl: self-checking bench for btn_mod_ctrl with a behavioural model.
module tb_btn_mod_ctrl;

    localparam int DB  = 4;
    localparam int SEC = 10;
    localparam int TO  = 20;
    localparam int REP = 16;

    logic       ckht = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mod = 1'b0;
    logic       act_in = 1'b0;
    logic       mode_active = 1'b0;
    logic       ena_db, btn_level, sec_tick;
    logic [4:0] tg_nn;

    int n_pass = 0;
    int n_total = 0;

    btn_mod_ctrl #(
        .DB_CYCLES(DB), .SEC_CYCLES(SEC), .TIMEOUT_S(TO), .REPEAT_CYCLES(REP)
    ) dut (
        .ckht(ckht), .rst(rst), .btn_mod(btn_mod), .act_in(act_in),
        .mode_active(mode_active), .ena_db(ena_db), .btn_level(btn_level),
        .sec_tick(sec_tick), .tg_nn(tg_nn)
    );

    always #5 ckht = ~ckht;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural reference: the debounced level flips once the synchronised
    // input has disagreed with it for DB consecutive samples.
    logic m_s1 = 1'b0, m_s = 1'b0, m_lvl = 1'b0, m_ena = 1'b0, m_tick = 1'b0;
    int   m_run = 0, m_rep = 0, m_cnt = 0, m_tg = 0;
    logic n_lvl, n_ena, n_tick, flip, stay, rep_hit;
    int   n_run, n_rep, n_cnt, n_tg;

    always_comb begin
        n_run   = (m_s != m_lvl) ? m_run + 1 : 0;
        flip    = (n_run == DB);
        n_lvl   = flip ? ~m_lvl : m_lvl;
        if (flip) n_run = 0;
        stay    = m_lvl && (m_run == 0) && m_s;
        n_rep   = stay ? m_rep + 1 : 0;
        rep_hit = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        if (n_rep == REP) begin
            rep_hit = 1'b1;
            n_rep   = 0;
        end
`endif
        n_ena  = (flip && !m_lvl) || rep_hit;
        n_cnt  = m_cnt + 1;
        n_tick = (n_cnt % SEC) == 0;
        n_tg   = (m_ena || act_in || !mode_active) ? 0 :
                 (m_tick && m_tg < TO) ? m_tg + 1 : m_tg;
    end

    always @(posedge ckht) begin
        if (rst) begin
            m_s1 <= 1'b0; m_s <= 1'b0; m_lvl <= 1'b0; m_ena <= 1'b0;
            m_tick <= 1'b0; m_run <= 0; m_rep <= 0; m_cnt <= 0; m_tg <= 0;
        end else begin
            m_s1 <= btn_mod; m_s <= m_s1; m_lvl <= n_lvl; m_ena <= n_ena;
            m_tick <= n_tick; m_run <= n_run; m_rep <= n_rep; m_cnt <= n_cnt;
            m_tg <= n_tg;
        end
    end

    logic [7:0] got_v, exp_v;
    assign got_v = {ena_db, btn_level, sec_tick, tg_nn};
    assign exp_v = {m_ena, m_lvl, m_tick, 5'(m_tg)};

    task automatic test_reset();
        rst = 1'b1; btn_mod = 1'b0; act_in = 1'b0; mode_active = 1'b0;
        repeat (3) @(negedge ckht);
        n_total++;
        if (got_v !== 8'h00) $display("FAIL reset_outputs got=%b want=%b", got_v, 8'h00);
        else n_pass++;
        mode_active = 1'b1; btn_mod = 1'b1;
        @(negedge ckht);
        n_total++;
        if (got_v !== 8'h00) $display("FAIL reset_hold got=%b want=%b", got_v, 8'h00);
        else n_pass++;
        btn_mod = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_clean_press();
        btn_mod = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_press t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            n_total++;
            if (ena_db !== (i == DB + 2) || btn_level !== (i >= DB + 2))
                $display("FAIL press_latency cyc=%0d ena=%b lvl=%b want_ena=%b want_lvl=%b",
                         i, ena_db, btn_level, i == DB + 2, i >= DB + 2);
            else n_pass++;
        end
        btn_mod = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_release t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            n_total++;
            if (ena_db !== 1'b0 || btn_level !== (i < DB + 2))
                $display("FAIL release_latency cyc=%0d ena=%b lvl=%b want_ena=0 want_lvl=%b",
                         i, ena_db, btn_level, i < DB + 2);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int cnt = 0;
        for (int i = 0; i < 22; i++) begin
            btn_mod = (i < 6) ? pat[i] : 1'b1;
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_bounce t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            if (ena_db === 1'b1) cnt++;
        end
        n_total++;
        if (cnt !== 1) $display("FAIL bounce_pulses got=%0d want=1", cnt);
        else n_pass++;
        btn_mod = 1'b0;
        repeat (12) @(negedge ckht);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            btn_mod = (i < 3);
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_glitch t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            if (ena_db === 1'b1 || btn_level === 1'b1) cnt++;
        end
        n_total++;
        if (cnt !== 0) $display("FAIL glitch_ignored got=%0d active cycles want=0", cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        btn_mod = 1'b0; act_in = 1'b0; mode_active = 1'b0;
        @(negedge ckht);
        mode_active = 1'b1;
        for (int i = 0; i < 220; i++) begin
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_timeout t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
        end
        n_total++;
        if (tg_nn !== 5'(TO)) $display("FAIL tg_saturate got=%0d want=%0d", tg_nn, TO);
        else n_pass++;
        mode_active = 1'b0;
        @(negedge ckht);
        n_total++;
        if (tg_nn !== 5'd0) $display("FAIL tg_mode_clear got=%0d want=0", tg_nn);
        else n_pass++;
        mode_active = 1'b1;
    endtask

    task automatic test_simultaneous();
        bit found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_simul t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            if (m_tick && m_tg == 7) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL wait_tg7 got=timeout want=tg_nn 7 with sec_tick");
        else n_pass++;
        act_in = 1'b1;
        @(negedge ckht);
        act_in = 1'b0;
        n_total++;
        if (tg_nn !== 5'd0) $display("FAIL act_vs_tick got=%0d want=0", tg_nn);
        else n_pass++;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge ckht);
            if (m_tg == TO) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL wait_tg20 got=timeout want=tg_nn %0d", TO);
        else n_pass++;
        btn_mod = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge ckht);
            if (ena_db === 1'b1) found = 1;
        end
        n_total++;
        if (!found || tg_nn !== 5'(TO)) $display("FAIL ena_at_sat got=found:%0d tg=%0d want=found:1 tg=%0d", found, tg_nn, TO);
        else n_pass++;
        @(negedge ckht);
        n_total++;
        if (tg_nn !== 5'd0) $display("FAIL ena_vs_sat got=%0d want=0", tg_nn);
        else n_pass++;
        btn_mod = 1'b0;
        repeat (12) @(negedge ckht);
    endtask

    task automatic test_reset_mid_press();
        int cnt = 0;
        btn_mod = 1'b1;
        repeat (10) @(negedge ckht);
        n_total++;
        if (btn_level !== 1'b1) $display("FAIL held_level got=%b want=1", btn_level);
        else n_pass++;
        rst = 1'b1;
        @(negedge ckht);
        n_total++;
        if (got_v !== 8'h00) $display("FAIL rst_mid_outputs got=%b want=%b", got_v, 8'h00);
        else n_pass++;
        @(negedge ckht);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_rst_press t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            n_total++;
            if (ena_db !== (i == DB + 2)) $display("FAIL rst_repress cyc=%0d got=%b want=%b", i, ena_db, i == DB + 2);
            else n_pass++;
            if (ena_db === 1'b1) cnt++;
        end
        n_total++;
        if (cnt !== 1) $display("FAIL rst_one_pulse got=%0d want=1", cnt);
        else n_pass++;
        btn_mod = 1'b0;
        repeat (12) @(negedge ckht);
    endtask

    task automatic test_autorepeat();
        btn_mod = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            int  d = i - (DB + 2);
            logic want = (d == 0);
`ifdef BTN_AUTOREPEAT_EN
            want = want || (d > 0 && d % REP == 0);
`endif
            @(negedge ckht);
            n_total++;
            if (ena_db !== want) $display("FAIL autorepeat cyc=%0d got=%b want=%b", i, ena_db, want);
            else n_pass++;
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_hold t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
        end
        btn_mod = 1'b0;
        repeat (12) @(negedge ckht);
    endtask

    task automatic test_random();
        int run_left = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge ckht);
            n_total++;
            if (got_v !== exp_v) $display("FAIL model_random t=%0t got=%b want=%b", $time, got_v, exp_v);
            else n_pass++;
            if (run_left == 0) begin
                btn_mod  = ~btn_mod;
                run_left = int'($urandom_range(1, 24));
            end
            run_left--;
            act_in      = ($urandom_range(0, 15) == 0);
            mode_active = ($urandom_range(0, 31) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_timeout();
        test_simultaneous();
        test_reset_mid_press();
        test_autorepeat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/btn_mod_ctrl.md
# btn_mod_ctrl

Front-end for the mode button of the clock-setting path. Synchronises and debounces the raw `btn_mod` pin into a single-cycle `ena_db` pulse, and runs the seconds-based inactivity counter `tg_nn`. Together these feed the 2-bit mode counter directly downstream: `ena_db` advances the mode, and `tg_nn == TIMEOUT_S` returns it to mode 0. All logic runs on `posedge ckht`; outputs are registered and stable across the downstream `negedge` sample.

## Interface
- `DB_CYCLES`, 500_000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz)
- `SEC_CYCLES`, 50_000_000, ckht cycles per second tick
- `TIMEOUT_S`, 20, saturation value of `tg_nn`
- `REPEAT_CYCLES`, 25_000_000, auto-repeat period (only used with `BTN_AUTOREPEAT_EN`)
- `ckht  in  1  system clock`
- `rst  in  1  synchronous reset, active-high`
- `btn_mod  in  1  raw mode button, active-high, asynchronous to ckht`
- `act_in  in  1  activity pulse from the adjust buttons; restarts the idle count`
- `mode_active  in  1  high when the downstream mode is not 0`
- `ena_db  out  1  one-cycle pulse per accepted press`
- `btn_level  out  1  debounced button level`
- `sec_tick  out  1  one-cycle pulse every SEC_CYCLES cycles`
- `tg_nn  out  5  idle seconds, 0..TIMEOUT_S, saturating`

## Operation
- **Input sync:** 2-flop synchroniser on `btn_mod` produces `s`.
- **Debounce FSM:** states IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE. Counter `dc` is cleared on every state change.
  - IDLE: `s=1` → WAIT_PRESS.
  - WAIT_PRESS: `s=0` → IDLE. Otherwise `dc++`; when `dc == DB_CYCLES-1` → PRESSED and pulse `ena_db`.
  - PRESSED: `s=0` → WAIT_RELEASE.
  - WAIT_RELEASE: `s=1` → PRESSED, with no new pulse. Otherwise `dc++`; when `dc == DB_CYCLES-1` → IDLE.
- `btn_level` = 1 in PRESSED and WAIT_RELEASE; 0 otherwise.
- **Prescaler:** `pc` counts 0..SEC_CYCLES-1 and wraps. `sec_tick` = 1 on the wrap cycle. Only `rst` clears it.
- **Idle counter `tg_nn`**, in priority order:
  1. Clear if `ena_db | act_in | !mode_active`.
  2. Else, on `sec_tick`, increment if `tg_nn < TIMEOUT_S`.
  3. Else hold.
- Saturates at TIMEOUT_S and never wraps.
- Clear beats increment when both occur in the same cycle.
- `dc` and `pc` are sized with `$clog2` of their parameters; `tg_nn` is fixed at 5 bits. `TIMEOUT_S` ≤ 31 is checked by an elaboration-time check that stops elaboration with an error.

## Timing
- **Reset values:** state IDLE, `dc=0`, `pc=0`, `ena_db=0`, `btn_level=0`, `sec_tick=0`, `tg_nn=0`. Synchroniser flops also reset to 0.
- **Press latency:** `btn_mod` first sampled high at edge k and held → `ena_db` high for exactly the cycle after edge k+1+DB_CYCLES.
- `btn_level` rises on the same edge as `ena_db`.
- **Release latency:** DB_CYCLES+2 edges from first low sample to `btn_level=0`.
- **Glitches:** a glitch shorter than DB_CYCLES cycles produces no pulse and no level change.
- **Reset mid-press:** FSM returns to IDLE. A still-held button is re-debounced from zero and produces one pulse.
- `tg_nn` reaches TIMEOUT_S on the TIMEOUT_S-th `sec_tick` after the last clear. Tick phase is not realigned on clear, so the first second is 1..SEC_CYCLES cycles long.

## Configuration
- **`BTN_AUTOREPEAT_EN` defined:** while in PRESSED, a repeat counter emits an additional `ena_db` pulse every REPEAT_CYCLES cycles. The first repeat comes REPEAT_CYCLES cycles after the initial pulse. The repeat counter clears on leaving PRESSED.
- **Undefined:** exactly one pulse per press, repeat counter absent, and `REPEAT_CYCLES` ignored.

## Structure
- **Package `clk_set_pkg`:**
  - `db_state_t` enum (IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE)
  - `TG_W = 5`
  - `TIMEOUT_DEFAULT = 20`
  - mode encodings `MODE_RUN = 2'd0`, `MODE_SEC = 2'd1`, `MODE_MIN = 2'd2`, shared with the mode counter
- **Sub-module `sec_tick_gen`:** the prescaler (parameter SEC_CYCLES, output `sec_tick`). It is also reused by the timekeeping path.

## Test plan
Bench parameters: `DB_CYCLES=4`, `SEC_CYCLES=10`, `TIMEOUT_S=20`, `REPEAT_CYCLES=16`.

1. **Clean press:** `btn_mod` 0→1 held 20 cycles → single `ena_db` pulse 6 cycles after the first high sample; `btn_level=1`. Release → `btn_level=0` 6 cycles after the first low sample, no pulse.
2. **Bounce:** pattern 1,0,1,1,0,1 then held high → exactly one `ena_db` pulse. A 3-cycle high glitch → no pulse.
3. **Timeout:** `mode_active=1`, no activity for 200 cycles → `tg_nn` counts 0..20 on the `sec_tick` edges, then holds at 20. `mode_active`→0 → `tg_nn=0` next cycle.
4. **Simultaneous events:** `act_in` and `sec_tick` in the same cycle with `tg_nn=7` → `tg_nn=0`. `ena_db` while `tg_nn=20` → `tg_nn=0`.
5. **Reset mid-press:** `rst` asserted in PRESSED with button held → all outputs 0. After `rst` drops, one new pulse 6 cycles later.
6. **Auto-repeat (`BTN_AUTOREPEAT_EN`):** hold 60 cycles → pulses at t0, t0+16, t0+32, t0+48. Without the macro → pulse at t0 only.
